// File: rtl/alu_pkg.sv
// alu_pkg: shared encoder defaults and FIFO occupancy state encodings
package alu_pkg;
   localparam int LEN_DEF   = 8;
   localparam int WIDTH_DEF = 4;
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_HALF  = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;
endpackage

// File: rtl/nkb2onehot_core.sv
// nkb2onehot_core: combinational NKB code to 2*LEN-bit one-hot conversion
// ports: code (WIDTH-bit unsigned) in; oh ({B,A} one-hot) out; err (code >= 2*LEN) out
module nkb2onehot_core import alu_pkg::*; #(
   parameter int LEN   = LEN_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] code,
   output logic [2*LEN-1:0] oh,
   output logic             err
);
   assign err = 32'(code) >= 32'(2 * LEN);
   assign oh  = err ? '0 : (2 * LEN)'(1) << code;
endmodule

// File: rtl/nkb2onehot_encoder.sv
// nkb2onehot_encoder: valid/ready NKB-to-one-hot encoder with 2-entry output FIFO
// ports: i_CLK, i_RSTn (async active-low); i_VALID/o_READY/i_D upstream;
//        o_VALID/i_READY/o_A_OH/o_B_OH/o_ERR downstream
module nkb2onehot_encoder import alu_pkg::*; #(
   parameter int LEN   = LEN_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             i_CLK,
   input  logic             i_RSTn,
   input  logic             i_VALID,
   output logic             o_READY,
   input  logic [WIDTH-1:0] i_D,
   output logic             o_VALID,
   input  logic             i_READY,
   output logic [LEN-1:0]   o_A_OH,
   output logic [LEN-1:0]   o_B_OH,
   output logic             o_ERR
);
   localparam int W = 2 * LEN + 1;
   logic [1:0]       state, state_nxt;
   logic             wr_ptr, rd_ptr, in_fire, out_fire, enc_err;
   logic [W-1:0]     mem [2];
   logic [2*LEN-1:0] enc_oh;
   nkb2onehot_core #(.LEN(LEN), .WIDTH(WIDTH)) u_core (
      .code (i_D),
      .oh   (enc_oh),
      .err  (enc_err)
   );
   assign o_READY  = state != ST_FULL;
   assign o_VALID  = state != ST_EMPTY;
   assign in_fire  = i_VALID && o_READY;
   assign out_fire = o_VALID && i_READY;
   // simultaneous in+out keeps occupancy, so only one-sided transfers move state
   assign state_nxt = (in_fire && !out_fire) ? (state == ST_EMPTY ? ST_HALF : ST_FULL) :
                      (out_fire && !in_fire) ? (state == ST_FULL ? ST_HALF : ST_EMPTY) : state;
   assign {o_ERR, o_B_OH, o_A_OH} = o_VALID ? mem[rd_ptr] : '0;
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state  <= ST_EMPTY;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         state <= state_nxt;
         if (in_fire) begin
            mem[wr_ptr] <= {enc_err, enc_oh};
            wr_ptr      <= ~wr_ptr;
         end
         if (out_fire) rd_ptr <= ~rd_ptr;
      end
   end
endmodule

// File: tb/tb_nkb2onehot_encoder.sv
// tb_nkb2onehot_encoder: directed self-checking bench for nkb2onehot_encoder
module tb_nkb2onehot_encoder;
   logic       clk = 1'b0, rst_n = 1'b1;
   logic       v4 = 1'b0, r4 = 1'b0, v5 = 1'b0, r5 = 1'b0;
   logic [3:0] d4 = '0;
   logic [4:0] d5 = '0;
   logic       ordy4, ovld4, oerr4, ordy5, ovld5, oerr5;
   logic [7:0] a4, b4, a5, b5;
   int         checks = 0, failures = 0;
   always #5 clk = ~clk;
   nkb2onehot_encoder #(.LEN(8), .WIDTH(4)) u4 (
      .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(v4), .o_READY(ordy4), .i_D(d4),
      .o_VALID(ovld4), .i_READY(r4), .o_A_OH(a4), .o_B_OH(b4), .o_ERR(oerr4)
   );
   nkb2onehot_encoder #(.LEN(8), .WIDTH(5)) u5 (
      .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(v5), .o_READY(ordy5), .i_D(d5),
      .o_VALID(ovld5), .i_READY(r5), .o_A_OH(a5), .o_B_OH(b5), .o_ERR(oerr5)
   );
   task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed={rdy,vld,err,B,A}=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("reset4", {ordy4, ovld4, oerr4, b4, a4}, {3'b100, 16'h0000});
      chk("reset5", {ordy5, ovld5, oerr5, b5, a5}, {3'b100, 16'h0000});
      tick();
      tick();
      rst_n = 1'b1;
      // first edge after release accepts code 3
      v4 = 1'b1; d4 = 4'd3; r4 = 1'b1;
      tick();
      chk("code3", {ordy4, ovld4, oerr4, b4, a4}, {3'b110, 16'h0008});
      d4 = 4'd11;
      tick();
      chk("code11", {ordy4, ovld4, oerr4, b4, a4}, {3'b110, 16'h0800});
      v4 = 1'b0; d4 = 4'd5;
      tick();
      chk("drain_zero", {ordy4, ovld4, oerr4, b4, a4}, {3'b100, 16'h0000});
      tick();
      chk("ignore_d", {ordy4, ovld4, oerr4, b4, a4}, {3'b100, 16'h0000});
      // backpressure: 1,2 fill the FIFO, 3 must wait
      r4 = 1'b0; v4 = 1'b1; d4 = 4'd1;
      tick();
      chk("bp_half", {ordy4, ovld4, oerr4, b4, a4}, {3'b110, 16'h0002});
      d4 = 4'd2;
      tick();
      chk("bp_full", {ordy4, ovld4, oerr4, b4, a4}, {3'b010, 16'h0002});
      d4 = 4'd3;
      tick();
      chk("bp_hold", {ordy4, ovld4, oerr4, b4, a4}, {3'b010, 16'h0002});
      r4 = 1'b1;
      tick();
      chk("bp_word2", {ordy4, ovld4, oerr4, b4, a4}, {3'b110, 16'h0004});
      tick();
      chk("bp_word3", {ordy4, ovld4, oerr4, b4, a4}, {3'b110, 16'h0008});
      v4 = 1'b0;
      tick();
      chk("bp_empty", {ordy4, ovld4, oerr4, b4, a4}, {3'b100, 16'h0000});
      // full-rate streaming
      v4 = 1'b1;
      for (int k = 0; k < 16; k++) begin
         d4 = 4'(k);
         tick();
         chk($sformatf("stream%0d", k), {ordy4, ovld4, oerr4, b4, a4}, {3'b110, 16'(1) << k});
      end
      v4 = 1'b0;
      tick();
      chk("stream_end", {ordy4, ovld4, oerr4, b4, a4}, {3'b100, 16'h0000});
      // out-of-range codes on the 5-bit instance
      r5 = 1'b1; v5 = 1'b1; d5 = 5'd16;
      tick();
      chk("err16", {ordy5, ovld5, oerr5, b5, a5}, {3'b111, 16'h0000});
      d5 = 5'd31;
      tick();
      chk("err31", {ordy5, ovld5, oerr5, b5, a5}, {3'b111, 16'h0000});
      d5 = 5'd15;
      tick();
      chk("w5_code15", {ordy5, ovld5, oerr5, b5, a5}, {3'b110, 16'h8000});
      v5 = 1'b0;
      tick();
      chk("w5_empty", {ordy5, ovld5, oerr5, b5, a5}, {3'b100, 16'h0000});
      // async reset while FULL
      r4 = 1'b0; v4 = 1'b1; d4 = 4'd4;
      tick();
      d4 = 4'd6;
      tick();
      chk("pre_rst_full", {ordy4, ovld4, oerr4, b4, a4}, {3'b010, 16'h0010});
      v4 = 1'b0; r4 = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", {ordy4, ovld4, oerr4, b4, a4}, {3'b100, 16'h0000});
      #2 rst_n = 1'b1;
      tick();
      chk("no_stale", {ordy4, ovld4, oerr4, b4, a4}, {3'b100, 16'h0000});
      v4 = 1'b1; d4 = 4'd7;
      tick();
      chk("post_rst_accept", {ordy4, ovld4, oerr4, b4, a4}, {3'b110, 16'h0080});
      v4 = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nkb2onehot_encoder.md
NKB2ONEHOT_ENCODER -- requirements
Module: nkb2onehot_encoder

Interface
REQ-001 SHALL have parameter LEN, default 8, width of each one-hot output half.
REQ-002 SHALL have parameter WIDTH, default 4, input code width; legal range WIDTH >= log2(2*LEN).
REQ-003 SHALL have port i_CLK  input  1  clock, all state on rising edge.
REQ-004 SHALL have port i_RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_VALID  input  1  upstream code valid.
REQ-006 SHALL have port o_READY  output  1  encoder can accept a code.
REQ-007 SHALL have port i_D  input  WIDTH  unsigned (NKB) code.
REQ-008 SHALL have port o_VALID  output  1  encoded word valid.
REQ-009 SHALL have port i_READY  input  1  downstream accepts word.
REQ-010 SHALL have port o_A_OH  output  LEN  low half of one-hot vector {B,A}.
REQ-011 SHALL have port o_B_OH  output  LEN  high half of one-hot vector {B,A}.
REQ-012 SHALL have port o_ERR  output  1  code out of range.

Function
REQ-013 SHALL take an input transfer on a rising edge with i_VALID=1 and o_READY=1; output transfer on a rising edge with o_VALID=1 and i_READY=1.
REQ-014 SHALL encode code v < 2*LEN as {o_B_OH,o_A_OH} with only bit v set and o_ERR=0.
REQ-015 SHALL encode v >= 2*LEN as {o_B_OH,o_A_OH}=0 and o_ERR=1; word still transferred normally.
REQ-016 SHALL encode at input acceptance and store encoded word (2*LEN+1 bits) in a 2-entry FIFO.
REQ-017 SHALL have states EMPTY (0 words), HALF (1), FULL (2).
REQ-018 SHALL transition: EMPTY+in -> HALF; HALF+in only -> FULL; HALF+out only -> EMPTY; HALF+in+out -> HALF; FULL+out -> HALF; otherwise hold.
REQ-019 SHALL drive o_READY = (state != FULL) and o_VALID = (state != EMPTY), decoded from registered state only; no combinational path i_READY->o_READY or i_VALID->o_VALID.
REQ-020 SHALL present the oldest stored word on outputs; words leave in acceptance order, none lost or duplicated.
REQ-021 SHALL hold o_A_OH/o_B_OH/o_ERR stable while o_VALID=1 and i_READY=0.
REQ-022 SHALL give latency 1 cycle: code accepted at edge N in EMPTY is on outputs with o_VALID=1 after edge N.
REQ-023 SHALL sustain 1 word/cycle with i_VALID=i_READY=1 continuously.
REQ-024 SHALL ignore i_D when i_VALID=0 or o_READY=0.
REQ-025 SHALL drive outputs to 0 while o_VALID=0.

Reset
REQ-026 SHALL on i_RSTn=0 immediately force state EMPTY, both FIFO entries and pointers to 0, o_VALID=0, o_READY=1, o_A_OH=0, o_B_OH=0, o_ERR=0.
REQ-027 SHALL discard all stored words on reset mid-operation, including FULL.
REQ-028 SHALL accept a code on the first rising edge after i_RSTn deassertion.

Structure
REQ-029 SHALL place state encodings (EMPTY=2'b00, HALF=2'b01, FULL=2'b11) and LEN/WIDTH defaults in shared package alu_pkg.
REQ-030 SHALL isolate the combinational code-to-one-hot conversion in sub-module nkb2onehot_core (ports: code in, {B,A} out, err out), reusable by the ALU.

Verification (LEN=8 unless stated)
REQ-031 SHALL check: WIDTH=4, i_D=3 accepted, i_READY=1 -> next cycle o_VALID=1, o_A_OH=8'h08, o_B_OH=8'h00, o_ERR=0.
REQ-032 SHALL check: i_D=11 -> o_A_OH=8'h00, o_B_OH=8'h08, o_ERR=0.
REQ-033 SHALL check: WIDTH=5, i_D=16 and i_D=31 -> outputs 0, o_ERR=1, o_VALID=1.
REQ-034 SHALL check: i_READY=0, offer 1,2,3 back-to-back -> 1,2 accepted, o_READY=0 after second, output holds 8'h02; release i_READY -> words 8'h02, 8'h04, then 3 accepted and 8'h08, in order.
REQ-035 SHALL check: i_VALID=i_READY=1, codes 0..15 -> 16 consecutive output words, one per cycle, bit k set for code k.
REQ-036 SHALL check: FULL, assert i_RSTn=0 between edges -> o_VALID=0, o_READY=1, outputs 0 before next edge; no stale word after release.
